// File: rtl/multdiv_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
//   md_op_t    : operation code presented by execute
//   md_state_t : sequencing state of the unit
package multdiv_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/multdiv_unit_div_iter.sv
// Restoring divider datapath: one quotient bit per i_step cycle on unsigned
// magnitudes. The top FSM loads it with i_start and applies signs afterwards.
// Ports:
//   clk, resetn            clock / async active-low reset
//   i_start                load dividend/divisor, counter = WIDTH-1
//   i_step                 perform one shift/subtract step
//   i_dividend, i_divisor  unsigned operands captured on i_start
//   o_quot, o_rem          running quotient / partial remainder
//   o_last                 counter at zero: the current step is the final one
module multdiv_unit_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_last
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    // r_quot doubles as the dividend shift register: its MSB feeds the
    // remainder while quotient bits fill in from the bottom.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dvsr <= '0;
        end else if (i_start) begin
            r_quot <= i_dividend;
            r_rem  <= '0;
            r_dvsr <= i_divisor;
            r_cnt  <= CNT_W'(WIDTH - 1);
        end else if (i_step) begin
            if (!w_diff[WIDTH]) begin
                r_rem  <= w_diff[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle HI/LO arithmetic unit beside the execute stage.
// MULT/MULTU retime a behavioural product through a MUL_STAGES-deep shift
// register; DIV/DIVU use the iterative restoring divider plus one sign-fix
// cycle. MTHI/MTLO write directly from IDLE.
// Build option: define MULTDIV_MADD_EN to accept MADD/MADDU/MSUB/MSUBU
// (accumulate into {hi,lo}); otherwise those codes are ignored like MD_NONE.
// Ports:
//   clk, resetn      clock / async active-low reset
//   in_valid, op     request and operation code from execute
//   a, b             rs / rt operands
//   in_ready         high only in IDLE
//   flush            abort in-flight operation, no commit
//   busy             pipeline stall while an operation is in flight
//   done             one-cycle pulse after a HI/LO commit
//   hi, lo           architectural HI/LO registers
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | ready; MTHI/MTLO and 1-stage multiplies commit here
// MUL     | product travelling down the retiming pipe
// DIV     | restoring divider stepping, one bit per cycle
// FIX     | apply quotient/remainder signs, commit
module multdiv_unit
    import multdiv_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    md_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic [2*WIDTH-1:0] r_mul_pipe [MUL_STAGES];
    md_op_t             r_mul_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_a_raw;

    logic               w_op_legal;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_mul_signed;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_mul_now;
    logic [2*WIDTH-1:0] w_mul_late;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div_last;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Accumulating variants fold the product into the HI/LO value present
    // at the commit edge; plain multiplies just take the product.
    function automatic logic [2*WIDTH-1:0] mul_commit(
        input md_op_t             kind,
        input logic [2*WIDTH-1:0] acc,
        input logic [2*WIDTH-1:0] prod
    );
        case (kind)
            MD_MADD, MD_MADDU: mul_commit = acc + prod;
            MD_MSUB, MD_MSUBU: mul_commit = acc - prod;
            default:           mul_commit = prod;
        endcase
    endfunction

    always_comb begin
        w_op_legal = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: w_op_legal = 1'b1;
`ifdef MULTDIV_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU:                 w_op_legal = 1'b1;
`endif
            default:                                              w_op_legal = 1'b0;
        endcase
    end

    assign w_accept     = in_valid & in_ready & ~flush & w_op_legal;
    assign w_is_div     = (op == MD_DIV) | (op == MD_DIVU);
    assign w_is_mul     = (op == MD_MULT) | (op == MD_MULTU) | (op == MD_MADD) |
                          (op == MD_MADDU) | (op == MD_MSUB) | (op == MD_MSUBU);
    assign w_mul_signed = (op == MD_MULT) | (op == MD_MADD) | (op == MD_MSUB);

    // Extending to 2*WIDTH before multiplying gives the exact signed or
    // unsigned product modulo 2^(2*WIDTH).
    assign w_a_ext   = w_mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign w_b_ext   = w_mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign w_product = w_a_ext * w_b_ext;

    assign w_mul_now  = mul_commit(op, {r_hi, r_lo}, w_product);
    assign w_mul_late = mul_commit(r_mul_op, {r_hi, r_lo}, r_mul_pipe[MUL_STAGES-1]);

    assign w_a_neg = (op == MD_DIV) & a[WIDTH-1];
    assign w_b_neg = (op == MD_DIV) & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    multdiv_unit_div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .clk        (clk),
        .resetn     (resetn),
        .i_start    (w_accept & w_is_div),
        .i_step     (r_state == ST_DIV),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_last     (w_div_last)
    );

    // Most-negative / -1 needs no special case: the magnitude quotient is
    // 2^(WIDTH-1), signs agree, so lo comes out equal to a and hi to zero.
    assign w_quot_fix = r_neg_q ? -w_quot : w_quot;
    assign w_rem_fix  = r_neg_r ? -w_rem  : w_rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_mul_op   <= MD_NONE;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_raw    <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_mul_pipe[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_mul_pipe[i] <= r_mul_pipe[i-1];
            end
            if (w_accept & w_is_mul) begin
                r_mul_pipe[0] <= w_product;
            end

            if (flush) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            case (op)
                                MD_MTHI: begin
                                    r_hi   <= a;
                                    r_done <= 1'b1;
                                end
                                MD_MTLO: begin
                                    r_lo   <= a;
                                    r_done <= 1'b1;
                                end
                                MD_DIV, MD_DIVU: begin
                                    r_state    <= ST_DIV;
                                    r_neg_q    <= w_a_neg ^ w_b_neg;
                                    r_neg_r    <= w_a_neg;
                                    r_div_zero <= (b == '0);
                                    r_a_raw    <= a;
                                end
                                default: begin
                                    r_mul_op <= op;
                                    if (MUL_STAGES == 1) begin
                                        {r_hi, r_lo} <= w_mul_now;
                                        r_done       <= 1'b1;
                                    end else begin
                                        r_state <= ST_MUL;
                                        r_cnt   <= CNT_W'(MUL_STAGES - 1);
                                    end
                                end
                            endcase
                        end
                    end
                    ST_MUL: begin
                        if (r_cnt == '0) begin
                            {r_hi, r_lo} <= w_mul_late;
                            r_done       <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_DIV: begin
                        if (w_div_last) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        r_lo    <= r_div_zero ? '1 : w_quot_fix;
                        r_hi    <= r_div_zero ? r_a_raw : w_rem_fix;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign in_ready = ~busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;
    import multdiv_unit_pkg::*;

    localparam int W  = 32;
    localparam int MS = 3;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    md_op_t       op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    multdiv_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result {hi,lo} computed from plain integer arithmetic.
    function automatic logic [63:0] ref_model(input md_op_t o, input logic [31:0] x,
                                              input logic [31:0] y, input logic [31:0] h,
                                              input logic [31:0] l);
        longint          sp;
        longint unsigned up;
        int              sq;
        int              sr;
        case (o)
            MD_MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return 64'(sp);
            end
            MD_MULTU: begin
                up = longint'({32'h0, x}) * longint'({32'h0, y});
                return up;
            end
            MD_DIV: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
                sq = $signed(x) / $signed(y);
                sr = $signed(x) % $signed(y);
                return {32'(sr), 32'(sq)};
            end
            MD_DIVU: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            MD_MTHI: return {x, l};
            MD_MTLO: return {h, x};
            MD_MADDU: begin
                up = longint'({32'h0, x}) * longint'({32'h0, y});
                return {h, l} + up;
            end
            MD_MSUBU: begin
                up = longint'({32'h0, x}) * longint'({32'h0, y});
                return {h, l} - up;
            end
            MD_MADD: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return {h, l} + 64'(sp);
            end
            MD_MSUB: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return {h, l} - 64'(sp);
            end
            default: return {h, l};
        endcase
    endfunction

    function automatic int ref_latency(input md_op_t o);
        case (o)
            MD_MTHI, MD_MTLO: return 0;
            MD_DIV, MD_DIVU:  return W + 1;
            default:          return MS;
        endcase
    endfunction

    // Issue one operation, count busy cycles until done, compare against model.
    task automatic do_op(input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
        logic [63:0] exp;
        int          lat;
        bit          seen;
        bit          idle_no_done;
        bit          hold_ok;
        exp = ref_model(o, x, y, m_hi, m_lo);
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = MD_NONE;
        lat = 0; seen = 1'b0; idle_no_done = 1'b0; hold_ok = 1'b1;
        for (int i = 0; i < 100 && !seen && !idle_no_done; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) begin
                lat++;
                if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
            end else idle_no_done = 1'b1;
        end
        check({tag, " done seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(ref_latency(o)));
        check({tag, " hold"}, 64'(hold_ok), 64'd1);
        check({tag, " result"}, {hi, lo}, exp);
        check({tag, " busy after"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, " done pulse"}, 64'(done), 64'd0);
        {m_hi, m_lo} = exp;
    endtask

    // Present a request that must not be accepted.
    task automatic do_ignored(input md_op_t o, input logic fl, input string tag);
        @(negedge clk);
        op = o; a = $urandom; b = $urandom; in_valid = 1'b1; flush = fl;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = MD_NONE; flush = 1'b0;
        @(negedge clk);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        md_op_t ro;
        resetn = 1'b0; in_valid = 1'b0; op = MD_NONE; a = '0; b = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        resetn = 1'b1;

        do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, "mult -2*3");
        check("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
        check("multu const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        check("div const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(MD_DIVU, 32'd7, 32'd2, "divu 7/2");
        check("divu const", {hi, lo}, 64'h0000_0001_0000_0003);
        do_op(MD_DIV, 32'h1234, 32'h0, "div by zero");
        check("div0 const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        do_op(MD_DIVU, 32'h1234, 32'h0, "divu by zero");
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        check("ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(MD_MTHI, 32'hDEAD_BEEF, 32'h0, "mthi");
        check("mthi const", 64'(hi), 64'hDEAD_BEEF);
        do_op(MD_MTLO, 32'hCAFE_F00D, 32'h0, "mtlo");

        do_ignored(MD_NONE, 1'b0, "none ignored");
        do_ignored(MD_MULT, 1'b1, "flush blocks accept");
`ifdef MULTDIV_MADD_EN
        do_op(MD_MTHI, 32'h1, 32'h0, "pre hi");
        do_op(MD_MTLO, 32'hFFFF_FFFF, 32'h0, "pre lo");
        do_op(MD_MADDU, 32'h1, 32'h1, "maddu carry");
        check("maddu const", {hi, lo}, 64'h0000_0002_0000_0000);
        do_op(MD_MSUB, 32'hFFFF_FFFF, 32'h5, "msub");
        do_op(MD_MADD, 32'h7FFF_0000, 32'h8000_0001, "madd");
        do_op(MD_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "msubu");
`else
        do_ignored(MD_MADD, 1'b0, "madd ignored");
        do_ignored(MD_MSUBU, 1'b0, "msubu ignored");
`endif

        // Flush a divide in flight.
        do_op(MD_MTHI, 32'h55, 32'h0, "pre hi55");
        do_op(MD_MTLO, 32'h55, 32'h0, "pre lo55");
        @(negedge clk);
        op = MD_DIVU; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = MD_NONE;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("flush busy before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush hilo", {hi, lo}, 64'h0000_0055_0000_0055);
        @(negedge clk);
        check("flush no done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check("flush still no done", 64'(done), 64'd0);
        do_op(MD_MULTU, 32'h10, 32'h20, "multu after flush");

        // Asynchronous reset during a multiply.
        do_op(MD_MTHI, 32'hA5A5_A5A5, 32'h0, "pre rst hi");
        @(negedge clk);
        op = MD_MULT; a = 32'd9; b = 32'd9; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = MD_NONE;
        check("rst busy before", 64'(busy), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst hilo", {hi, lo}, 64'h0);
        check("rst busy", 64'(busy), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (MS + 1) @(negedge clk);
        check("rst no late commit", {hi, lo}, 64'h0);
        do_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult after rst");

        // Randomized operations.
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 5))
                0:       ro = MD_MULT;
                1:       ro = MD_MULTU;
                2:       ro = MD_DIV;
                3:       ro = MD_DIVU;
                4:       ro = MD_MTHI;
                default: ro = MD_MTLO;
            endcase
            do_op(ro, pick_val(), pick_val(), {"rand ", ro.name()});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multi-cycle HI/LO arithmetic unit beside the execute stage. Handles MULT/MULTU/DIV/DIVU/MTHI/MTLO; the decode path reads HI/LO for MFHI/MFLO.
- Execute presents one operation per handshake. The unit stalls the pipeline via busy until the HI/LO result is committed.
- Parametrised successor to the single-cycle execute ALU: configurable data width and multiplier depth, with an iterative divider.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_STAGES, 3, multiply latency in cycles from accept to HI/LO commit; legal range 1..8.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  operation request from execute
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  4  md_op_t operation code
- a  in  WIDTH  rs operand (dividend / multiplicand / MT source)
- b  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  abort in-flight operation (exception/redirect)
- busy  out  1  stall request to pipeline
- done  out  1  one-cycle pulse: HI/LO just committed
- hi  out  WIDTH  architectural HI register
- lo  out  WIDTH  architectural LO register

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, hi=0, lo=0, done=0, busy=0, in_ready=1, counter=0, and all partial-result registers cleared.
- Accept: happens on a rising edge with in_valid & in_ready & op!=MD_NONE. An op of MD_NONE is ignored.
- States: IDLE, MUL, DIV, FIX.
- IDLE accepting MTHI/MTLO: write a into hi/lo at the accept edge. done=1 in the following cycle. State stays IDLE; no busy.
- IDLE accepting MULT/MULTU: state becomes MUL, counter=MUL_STAGES-1.
  - The product {hi,lo} is written at the edge MUL_STAGES cycles after accept. When MUL_STAGES=1 it is written at the accept edge itself and the state stays IDLE.
  - MULT is signed 2·WIDTH-bit; MULTU is unsigned.
- IDLE accepting DIV/DIVU: latch |a| and |b| (raw values for DIVU) and the sign flags. State becomes DIV, counter=WIDTH-1.
  - DIV is restoring division, 1 quotient bit per cycle, WIDTH cycles, then FIX for 1 cycle.
  - FIX applies signs: quotient is negated if the signs of a and b differ; remainder takes the sign of a.
  - Commit lo=quotient, hi=remainder at the FIX exit edge. Total latency is WIDTH+1 cycles after accept.
- Divide by zero (b==0): no exception. lo=all-ones, hi=a, for both signed and unsigned. Latency is unchanged.
- Signed overflow (a=most-negative, b=-1): lo=a, hi=0.
- busy=1 whenever state!=IDLE. in_ready=~busy.
- done is registered: high for exactly the one cycle after any HI/LO commit edge.
- hi/lo outputs change only at commit edges. While busy they hold the old values, so the pipeline must stall MFHI/MFLO on busy.
- flush: on the next edge the state returns to IDLE and hi/lo are left unchanged; no done pulse.
  - flush on the same edge as a commit: the commit is suppressed.
  - flush together with in_valid in IDLE: the request is not accepted.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro MULTDIV_MADD_EN enables MD_MADD, MD_MADDU, MD_MSUB and MD_MSUBU.
  - Each uses the same MUL path and latency.
  - At the commit edge, {hi,lo} = {hi,lo} ± product, wrapping mod 2^(2·WIDTH). The sampled hi/lo are those at the commit edge.
- Without the macro, these four codes are treated as MD_NONE: not accepted, no state change.

Decomposition:
- Shared pipeline package holds:
  - typedef enum logic [3:0] md_op_t: MD_NONE=0, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU.
  - The md_state_t enum.
- One natural sub-module: div_iter, the restoring divider datapath (shift/subtract step plus counter). The top FSM sequences it.
- The multiplier is a behavioural product retimed through a MUL_STAGES-deep shift register; it is not a separate module.

Test Plan:
- MULT, WIDTH=32, MUL_STAGES=3:
  - a=0xFFFFFFFE (-2), b=3: busy for 3 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
  - MULTU with the same operands: hi=0x00000002, lo=0xFFFFFFFA.
- DIV:
  - a=-7 (0xFFFFFFF9), b=2: after 33 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU a=7, b=2: lo=3, hi=1.
- Boundaries:
  - DIV by zero a=0x1234, b=0: lo=0xFFFFFFFF, hi=0x1234.
  - DIV a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF: hi=0xDEADBEEF the next cycle, busy never asserted, done pulses once.
- Preload hi=lo=0x55, start DIVU, assert flush at cycle 10: state returns to IDLE, hi=lo=0x55, no done. A new MULTU is accepted the next cycle.
- resetn low during a MUL: hi/lo go to 0 asynchronously and busy drops.
- With MULTDIV_MADD_EN: preload {hi,lo}=0x0000_0001_FFFF_FFFF, MADDU a=1, b=1 → hi=2, lo=0 (carry across halves).
